tx_serialiser: RTL and testbench



---
 rtl/tx_serialiser_if.sv | 21 ++
 rtl/tx_serialiser.sv | 126 ++++++++++++
 tb/tb_tx_serialiser.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_serialiser_if.sv
// Tx handshake bundle between the byte source, the serialiser and the bit encoder.
// The master side drives bytes in and pulls bits out; the slave side is the serialiser.
interface tx_serialiser_if;
    logic [7:0] in_data;
    logic       in_data_valid;
    logic [2:0] in_data_bits;
    logic       in_req;
    logic       out_data;
    logic       out_data_valid;
    logic       out_req;

    modport master (
        output in_data, in_data_valid, in_data_bits, out_req,
        input  in_req, out_data, out_data_valid
    );

    modport slave (
        input  in_data, in_data_valid, in_data_bits, out_req,
        output in_req, out_data, out_data_valid
    );
endinterface

// File: rtl/tx_serialiser.sv
// Byte-to-bit Tx serialiser, LSB first, with optional ISO/IEC 14443A odd parity after full bytes.
// Define TX_SERIALISER_PARITY_EN to enable the parity bit; undefined, every byte emits only its data bits.
module tx_serialiser (
    input  logic          clk,
    input  logic          rst,
    tx_serialiser_if.slave bus
);

`ifdef TX_SERIALISER_PARITY_EN
    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] rem_q, rem_d;
    logic       out_valid_q, out_valid_d;
    logic       in_req_q, in_req_d;
    logic       load_en;
    logic       end_en;
`ifdef TX_SERIALISER_PARITY_EN
    logic       full_byte_q, full_byte_d;
    logic       parity_q, parity_d;
`endif

    // shift_q[0] is the bit on the wire; rem_q counts bits still to come after it,
    // so a full byte loads 7 and the 3-bit counter never needs to hold 8.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        in_req_d    = 1'b0;
        load_en     = 1'b0;
        end_en      = 1'b0;
`ifdef TX_SERIALISER_PARITY_EN
        full_byte_d = full_byte_q;
        parity_d    = parity_q;
`endif

        case (state_q)
            IDLE: begin
                load_en = bus.in_data_valid;
            end
            DATA: begin
                if (bus.out_req) begin
                    if (rem_q != 3'd0) begin
                        shift_d = {1'b0, shift_q[7:1]};
                        rem_d   = rem_q - 3'd1;
                    end
`ifdef TX_SERIALISER_PARITY_EN
                    else if (full_byte_q) begin
                        state_d = PARITY;
                        shift_d = {7'b0, parity_q};
                    end
`endif
                    else begin
                        end_en = 1'b1;
                    end
                end
            end
`ifdef TX_SERIALISER_PARITY_EN
            PARITY: begin
                end_en = bus.out_req;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // End of a byte: chain straight into the next one if upstream already has it.
        if (end_en) begin
            if (bus.in_data_valid) begin
                load_en = 1'b1;
            end else begin
                state_d     = IDLE;
                shift_d     = 8'd0;
                rem_d       = 3'd0;
                out_valid_d = 1'b0;
            end
        end

        if (load_en) begin
            state_d     = DATA;
            shift_d     = bus.in_data;
            rem_d       = bus.in_data_bits - 3'd1;
            out_valid_d = 1'b1;
            in_req_d    = 1'b1;
`ifdef TX_SERIALISER_PARITY_EN
            full_byte_d = (bus.in_data_bits == 3'd0);
            parity_d    = ~^bus.in_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= 8'd0;
            rem_q       <= 3'd0;
            out_valid_q <= 1'b0;
            in_req_q    <= 1'b0;
`ifdef TX_SERIALISER_PARITY_EN
            full_byte_q <= 1'b0;
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            in_req_q    <= in_req_d;
`ifdef TX_SERIALISER_PARITY_EN
            full_byte_q <= full_byte_d;
            parity_q    <= parity_d;
`endif
        end
    end

    assign bus.out_data       = shift_q[0];
    assign bus.out_data_valid = out_valid_q;
    assign bus.in_req         = in_req_q;

endmodule

// File: tb/tb_tx_serialiser.sv
// Self-checking bench for tx_serialiser: table vectors, hand-written corner sequences
// and randomized byte streams checked against a bit-list reference model.
module tb_tx_serialiser;

`ifdef TX_SERIALISER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic rst;

    tx_serialiser_if bus();

    tx_serialiser dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [2:0] bits;
    } tx_t;

    typedef struct {
        logic [7:0] data;
        logic [2:0] bits;
        logic [8:0] exp_bits;
        int         exp_len;
        string      name;
    } vec_t;

    tx_t  tx_q[$];
    logic exp_q[$];
    vec_t vecs[7];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input int idx);
        if (idx < tx_q.size()) begin
            bus.in_data       = tx_q[idx].data;
            bus.in_data_bits  = tx_q[idx].bits;
            bus.in_data_valid = 1'b1;
        end else begin
            bus.in_data_valid = 1'b0;
            bus.in_data       = 8'($urandom);
        end
    endtask

    // Reference model: a byte is its first n bits LSB-first, plus an odd-parity bit for full bytes.
    task automatic model_push(input logic [7:0] d, input logic [2:0] b);
        int n;
        n = (b == 3'd0) ? 8 : int'(b);
        tx_q.push_back('{d, b});
        for (int k = 0; k < n; k++) exp_q.push_back(d[k]);
        if (PAR == 1 && b == 3'd0) exp_q.push_back(($countones(d) % 2) == 0);
    endtask

    // Plays the byte queue through the DUT, pulsing out_req every gmin..gmax ticks.
    task automatic run_stream(input string name, input int gmin, input int gmax);
        int n_bytes;
        int byte_idx;
        int inreq_cnt;
        int bit_idx;
        int wait_cnt;
        int gap;
        int budget;
        int bad_inreq;
        int gaps;
        bit prev_req;
        bit prev_inreq;
        bit prev_valid;
        bit started;
        logic exp_bit;
        n_bytes = tx_q.size();
        byte_idx = 0; inreq_cnt = 0; bit_idx = 0; wait_cnt = 0; budget = 0;
        bad_inreq = 0; gaps = 0;
        prev_req = 1'b0; prev_inreq = 1'b0; prev_valid = 1'b0; started = 1'b0;
        gap = gmin;
        present(0);
        while (exp_q.size() != 0 && budget < 4000) begin
            budget++;
            tick();
            bus.out_req = 1'b0;
            if (bus.in_req === 1'b1) begin
                if (!((prev_req || !prev_valid) && !prev_inreq)) bad_inreq++;
                inreq_cnt++;
                byte_idx++;
                present(byte_idx);
            end
            if (started && bus.out_data_valid !== 1'b1) gaps++;
            if (bus.out_data_valid === 1'b1) begin
                started = 1'b1;
                wait_cnt++;
                if (wait_cnt >= gap) begin
                    exp_bit = exp_q.pop_front();
                    check($sformatf("%s bit%0d", name, bit_idx), 32'(bus.out_data), 32'(exp_bit));
                    bit_idx++;
                    bus.out_req = 1'b1;
                    wait_cnt = 0;
                    gap = $urandom_range(gmax, gmin);
                end
            end
            prev_req   = bus.out_req;
            prev_inreq = bus.in_req;
            prev_valid = bus.out_data_valid;
        end
        if (exp_q.size() != 0) begin
            check($sformatf("%s timeout_bits_left", name), exp_q.size(), 0);
            exp_q.delete();
        end
        tick();
        bus.out_req = 1'b0;
        check($sformatf("%s valid_drop", name), 32'(bus.out_data_valid), 0);
        check($sformatf("%s in_req_count", name), inreq_cnt, n_bytes);
        check($sformatf("%s in_req_at_load", name), bad_inreq, 0);
        check($sformatf("%s valid_gaps", name), gaps, 0);
        tx_q.delete();
        bus.in_data_valid = 1'b0;
        repeat (2) tick();
    endtask

    // Finishes an already-started byte and returns how many bits it emitted.
    task automatic drain(output int nbits);
        nbits = 0;
        for (int i = 0; i < 20; i++) begin
            repeat (8) tick();
            if (bus.out_data_valid !== 1'b1) break;
            bus.out_req = 1'b1;
            tick();
            bus.out_req = 1'b0;
            nbits++;
        end
    endtask

    initial begin
        int nb;
        int drained;

        vecs[0] = '{8'hA5, 3'd0, 9'h1A5, 8 + PAR, "A5_full"};
        vecs[1] = '{8'h26, 3'd7, 9'h026, 7,       "26_7bit"};
        vecs[2] = '{8'hFF, 3'd0, 9'h1FF, 8 + PAR, "FF_full"};
        vecs[3] = '{8'h0F, 3'd0, 9'h10F, 8 + PAR, "0F_full"};
        vecs[4] = '{8'h03, 3'd2, 9'h003, 2,       "03_2bit"};
        vecs[5] = '{8'h80, 3'd1, 9'h000, 1,       "80_1bit"};
        vecs[6] = '{8'h07, 3'd0, 9'h007, 8 + PAR, "07_full"};

        rst = 1'b1;
        bus.in_data = 8'h00;
        bus.in_data_bits = 3'd0;
        bus.in_data_valid = 1'b0;
        bus.out_req = 1'b0;
        repeat (3) tick();
        check("reset out_data", 32'(bus.out_data), 0);
        check("reset out_data_valid", 32'(bus.out_data_valid), 0);
        check("reset in_req", 32'(bus.in_req), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            tx_q.push_back('{vecs[i].data, vecs[i].bits});
            for (int k = 0; k < vecs[i].exp_len; k++) exp_q.push_back(vecs[i].exp_bits[k]);
            run_stream(vecs[i].name, 8, 8);
        end

        // Back-to-back 0x01 then 0x00 with no gap in valid.
        tx_q.push_back('{8'h01, 3'd0});
        tx_q.push_back('{8'h00, 3'd0});
        exp_q.push_back(1'b1);
        repeat (7) exp_q.push_back(1'b0);
        if (PAR == 1) exp_q.push_back(1'b0);
        repeat (8) exp_q.push_back(1'b0);
        if (PAR == 1) exp_q.push_back(1'b1);
        run_stream("b2b_01_00", 8, 8);

        // Reset mid-byte of 0xFF, simultaneous with an out_req pulse.
        bus.in_data = 8'hFF;
        bus.in_data_bits = 3'd0;
        bus.in_data_valid = 1'b1;
        check("rst_mid pre valid", 32'(bus.out_data_valid), 0);
        tick();
        check("rst_mid start valid", 32'(bus.out_data_valid), 1);
        check("rst_mid start in_req", 32'(bus.in_req), 1);
        check("rst_mid start bit0", 32'(bus.out_data), 1);
        bus.in_data_valid = 1'b0;
        for (int p = 0; p < 3; p++) begin
            repeat (8) tick();
            bus.out_req = 1'b1;
            tick();
            bus.out_req = 1'b0;
        end
        check("rst_mid bit3 valid", 32'(bus.out_data_valid), 1);
        check("rst_mid bit3", 32'(bus.out_data), 1);
        repeat (7) tick();
        rst = 1'b1;
        bus.out_req = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_req = 1'b0;
        check("rst_mid after valid", 32'(bus.out_data_valid), 0);
        check("rst_mid after data", 32'(bus.out_data), 0);
        check("rst_mid after in_req", 32'(bus.in_req), 0);
        repeat (3) tick();
        check("rst_mid idle valid", 32'(bus.out_data_valid), 0);
        model_push(8'h0F, 3'd0);
        run_stream("rst_restart_0F", 8, 8);

        // out_req pulses in IDLE are ignored; then 1-tick start latency.
        for (int p = 0; p < 3; p++) begin
            bus.out_req = 1'b1;
            tick();
            bus.out_req = 1'b0;
            tick();
            check($sformatf("idle_req%0d valid", p), 32'(bus.out_data_valid), 0);
            check($sformatf("idle_req%0d data", p), 32'(bus.out_data), 0);
            check($sformatf("idle_req%0d in_req", p), 32'(bus.in_req), 0);
        end
        bus.in_data = 8'h0F;
        bus.in_data_bits = 3'd0;
        bus.in_data_valid = 1'b1;
        tick();
        check("idle_start valid", 32'(bus.out_data_valid), 1);
        check("idle_start in_req", 32'(bus.in_req), 1);
        check("idle_start bit0", 32'(bus.out_data), 1);
        bus.in_data_valid = 1'b0;
        tick();
        check("idle_start in_req_one_tick", 32'(bus.in_req), 0);
        drain(drained);
        check("idle_start bit_count", drained, 8 + PAR);
        repeat (2) tick();

        // Randomized streams of 1..3 bytes, full bytes favoured.
        for (int s = 0; s < 30; s++) begin
            nb = $urandom_range(3, 1);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(1, 0) == 1) model_push(8'($urandom), 3'd0);
                else model_push(8'($urandom), 3'($urandom_range(7, 1)));
            end
            run_stream($sformatf("rand%0d", s), 8, 12);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
